// File: rtl/sqn_allocator_pkg.sv
// ============================================================================
// Module      : sqn_allocator_pkg
// Description : Shared types, default queue sizes and configuration checks
//               for the sequence-number allocator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DEC_WIDTH
`define DEC_WIDTH 4
`endif

package sqn_allocator_pkg;

    localparam int c_def_sqn_w    = 7;
    localparam int c_def_rob_size = 64;
    localparam int c_def_lq_size  = 32;
    localparam int c_def_sq_size  = 32;

    // Sequence number at the default width.
    typedef logic [c_def_sqn_w-1:0] sqn_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Every queue must be a power of two, and the number space must be at
    // least twice the largest queue so that alloc - com never aliases.
    function automatic bit sizes_ok(input int sqn_w, input int rob,
                                    input int lq, input int sq);
        int m;
        m = rob;
        if (lq > m) m = lq;
        if (sq > m) m = sq;
        return is_pow2(rob) && is_pow2(lq) && is_pow2(sq) &&
               (sqn_w < 31) && ((1 << sqn_w) >= (2 * m));
    endfunction

endpackage

`default_nettype wire

// File: rtl/sqn_allocator_popcount_prefix.sv
// ============================================================================
// Module      : popcount_prefix
// Description : Per-bit prefix population count (exclusive or inclusive)
//               plus the total count of set bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_prefix
    import sqn_allocator_pkg::*;
#(
    parameter int N         = 4,
    parameter bit INCLUSIVE = 1'b0,
    parameter int CNT_W     = $clog2(N + 1)
) (
    input  logic [N-1:0]            bits_i,
    output logic [N-1:0][CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0]        total_o
);

    logic [CNT_W-1:0] w_acc;

    // Running sum; exclusive mode reports the count before adding bit i.
    always_comb begin
        w_acc = '0;
        cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            if (INCLUSIVE) begin
                w_acc    = w_acc + CNT_W'(bits_i[i]);
                cnt_o[i] = w_acc;
            end else begin
                cnt_o[i] = w_acc;
                w_acc    = w_acc + CNT_W'(bits_i[i]);
            end
        end
        total_o = w_acc;
    end

endmodule

`default_nettype wire

// File: rtl/sqn_allocator.sv
// ============================================================================
// Module      : sqn_allocator
// Description : Allocates ROB / load-queue / store-queue sequence numbers to
//               an issue group (all-or-nothing), tracks retirement and
//               restores allocation pointers on flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqn_allocator
    import sqn_allocator_pkg::*;
#(
    parameter int WIDTH_ISSUE  = `DEC_WIDTH,
    parameter int WIDTH_COMMIT = `DEC_WIDTH,
    parameter int ROB_SIZE     = c_def_rob_size,
    parameter int LQ_SIZE      = c_def_lq_size,
    parameter int SQ_SIZE      = c_def_sq_size,
    parameter int SQN_W        = c_def_sqn_w
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                IN_frontEn,
    input  logic                                IN_stall,
    input  logic [WIDTH_ISSUE-1:0]              IN_valid,
    input  logic [WIDTH_ISSUE-1:0]              IN_isLoad,
    input  logic [WIDTH_ISSUE-1:0]              IN_isStore,
    input  logic [WIDTH_COMMIT-1:0]             IN_comValid,
    input  logic [WIDTH_COMMIT-1:0]             IN_comIsLoad,
    input  logic [WIDTH_COMMIT-1:0]             IN_comIsStore,
    input  logic                                IN_flush,
    input  logic [SQN_W-1:0]                    IN_flushSqN,
    input  logic [SQN_W-1:0]                    IN_flushLoadSqN,
    input  logic [SQN_W-1:0]                    IN_flushStoreSqN,
    output logic                                OUT_stall,
    output logic [WIDTH_ISSUE-1:0]              OUT_valid,
    output logic [WIDTH_ISSUE-1:0][SQN_W-1:0]   OUT_sqN,
    output logic [WIDTH_ISSUE-1:0][SQN_W-1:0]   OUT_loadSqN,
    output logic [WIDTH_ISSUE-1:0][SQN_W-1:0]   OUT_storeSqN,
    output logic [SQN_W-1:0]                    OUT_robFree,
    output logic [SQN_W-1:0]                    OUT_lqFree,
    output logic [SQN_W-1:0]                    OUT_sqFree
);

    localparam int              c_ic_w     = $clog2(WIDTH_ISSUE + 1);
    localparam int              c_cc_w     = $clog2(WIDTH_COMMIT + 1);
    localparam logic [SQN_W-1:0] c_rob_size = SQN_W'(ROB_SIZE);
    localparam logic [SQN_W-1:0] c_lq_size  = SQN_W'(LQ_SIZE);
    localparam logic [SQN_W-1:0] c_sq_size  = SQN_W'(SQ_SIZE);
    localparam logic [SQN_W-1:0] c_one      = SQN_W'(1);

    generate
        if (!sizes_ok(SQN_W, ROB_SIZE, LQ_SIZE, SQ_SIZE)) begin : g_bad_cfg
            $error("sqn_allocator: queue sizes must be powers of two and 2^SQN_W >= 2*max size");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Demand / prefix counts
    // ------------------------------------------------------------------
    logic [WIDTH_ISSUE-1:0]              w_ld_mask, w_st_mask;
    logic [WIDTH_ISSUE-1:0][c_ic_w-1:0]  w_pre_v, w_pre_ld, w_pre_st;
    logic [c_ic_w-1:0]                   w_dem_v, w_dem_ld, w_dem_st;
    logic [WIDTH_COMMIT-1:0]             w_com_ld_mask, w_com_st_mask;
    logic [WIDTH_COMMIT-1:0][c_cc_w-1:0] w_cpre_v, w_cpre_ld, w_cpre_st;
    logic [c_cc_w-1:0]                   w_ccnt_v, w_ccnt_ld, w_ccnt_st;
    logic                                w_com_prefix_unused;

    assign w_ld_mask     = IN_valid & IN_isLoad;
    assign w_st_mask     = IN_valid & IN_isStore;
    assign w_com_ld_mask = IN_comValid & IN_comIsLoad;
    assign w_com_st_mask = IN_comValid & IN_comIsStore;

    // Commit side only needs totals; per-slot prefixes are dropped here.
    assign w_com_prefix_unused = ^{w_cpre_v, w_cpre_ld, w_cpre_st};

    popcount_prefix #(.N(WIDTH_ISSUE), .INCLUSIVE(1'b0)) u_pc_iss_v (
        .bits_i(IN_valid),  .cnt_o(w_pre_v),  .total_o(w_dem_v));
    popcount_prefix #(.N(WIDTH_ISSUE), .INCLUSIVE(1'b0)) u_pc_iss_ld (
        .bits_i(w_ld_mask), .cnt_o(w_pre_ld), .total_o(w_dem_ld));
    // Store counter holds the last allocated number, hence inclusive prefix.
    popcount_prefix #(.N(WIDTH_ISSUE), .INCLUSIVE(1'b1)) u_pc_iss_st (
        .bits_i(w_st_mask), .cnt_o(w_pre_st), .total_o(w_dem_st));
    popcount_prefix #(.N(WIDTH_COMMIT), .INCLUSIVE(1'b0)) u_pc_com_v (
        .bits_i(IN_comValid),   .cnt_o(w_cpre_v),  .total_o(w_ccnt_v));
    popcount_prefix #(.N(WIDTH_COMMIT), .INCLUSIVE(1'b0)) u_pc_com_ld (
        .bits_i(w_com_ld_mask), .cnt_o(w_cpre_ld), .total_o(w_ccnt_ld));
    popcount_prefix #(.N(WIDTH_COMMIT), .INCLUSIVE(1'b0)) u_pc_com_st (
        .bits_i(w_com_st_mask), .cnt_o(w_cpre_st), .total_o(w_ccnt_st));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SQN_W-1:0] alloc_sqn_q, alloc_sqn_d, alloc_ld_q, alloc_ld_d;
    logic [SQN_W-1:0] alloc_st_q, alloc_st_d;
    logic [SQN_W-1:0] com_sqn_q, com_sqn_d, com_ld_q, com_ld_d;
    logic [SQN_W-1:0] com_st_q, com_st_d;

    logic [WIDTH_ISSUE-1:0]            out_valid_q, out_valid_d;
    logic [WIDTH_ISSUE-1:0][SQN_W-1:0] out_sqn_q, out_sqn_d;
    logic [WIDTH_ISSUE-1:0][SQN_W-1:0] out_ld_q, out_ld_d;
    logic [WIDTH_ISSUE-1:0][SQN_W-1:0] out_st_q, out_st_d;
    logic [SQN_W-1:0] rob_free_q, rob_free_d, lq_free_q, lq_free_d;
    logic [SQN_W-1:0] sq_free_q, sq_free_d;

    // Free counts of the current state; the store counter is one behind.
    logic [SQN_W-1:0] w_rob_free, w_lq_free, w_sq_free;
    logic             w_over, w_accept;

    assign w_rob_free = c_rob_size - (alloc_sqn_q - com_sqn_q);
    assign w_lq_free  = c_lq_size  - (alloc_ld_q - com_ld_q);
    assign w_sq_free  = c_sq_size  - ((alloc_st_q + c_one) - com_st_q);

    assign w_over = (SQN_W'(w_dem_v)  > w_rob_free) ||
                    (SQN_W'(w_dem_ld) > w_lq_free)  ||
                    (SQN_W'(w_dem_st) > w_sq_free);

    assign OUT_stall = !rst || IN_stall || (IN_frontEn && w_over);
    assign w_accept  = rst && !IN_flush && IN_frontEn && !OUT_stall;

    // Next-state: flush restore beats acceptance; commits always apply.
    always_comb begin
        alloc_sqn_d = alloc_sqn_q;
        alloc_ld_d  = alloc_ld_q;
        alloc_st_d  = alloc_st_q;
        com_sqn_d   = com_sqn_q + SQN_W'(w_ccnt_v);
        com_ld_d    = com_ld_q  + SQN_W'(w_ccnt_ld);
        com_st_d    = com_st_q  + SQN_W'(w_ccnt_st);
        out_valid_d = out_valid_q;
        out_sqn_d   = out_sqn_q;
        out_ld_d    = out_ld_q;
        out_st_d    = out_st_q;

        if (IN_flush) begin
            alloc_sqn_d = IN_flushSqN + c_one;
            alloc_ld_d  = IN_flushLoadSqN;
            alloc_st_d  = IN_flushStoreSqN;
            out_valid_d = '0;
        end else if (w_accept) begin
            alloc_sqn_d = alloc_sqn_q + SQN_W'(w_dem_v);
            alloc_ld_d  = alloc_ld_q  + SQN_W'(w_dem_ld);
            alloc_st_d  = alloc_st_q  + SQN_W'(w_dem_st);
            out_valid_d = IN_valid;
            for (int i = 0; i < WIDTH_ISSUE; i++) begin
                out_sqn_d[i] = alloc_sqn_q + SQN_W'(w_pre_v[i]);
                out_ld_d[i]  = alloc_ld_q  + SQN_W'(w_pre_ld[i]);
                out_st_d[i]  = alloc_st_q  + SQN_W'(w_pre_st[i]);
            end
        end else if (!IN_stall) begin
            out_valid_d = '0;
        end

        // Free counts track the counters every cycle (also under stall) so
        // retirement during backpressure is visible immediately.
        rob_free_d = c_rob_size - (alloc_sqn_d - com_sqn_d);
        lq_free_d  = c_lq_size  - (alloc_ld_d - com_ld_d);
        sq_free_d  = c_sq_size  - ((alloc_st_d + c_one) - com_st_d);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alloc_sqn_q <= '0;
            alloc_ld_q  <= '0;
            alloc_st_q  <= '1;
            com_sqn_q   <= '0;
            com_ld_q    <= '0;
            com_st_q    <= '0;
            out_valid_q <= '0;
            out_sqn_q   <= '0;
            out_ld_q    <= '0;
            out_st_q    <= '0;
            rob_free_q  <= c_rob_size;
            lq_free_q   <= c_lq_size;
            sq_free_q   <= c_sq_size;
        end else begin
            alloc_sqn_q <= alloc_sqn_d;
            alloc_ld_q  <= alloc_ld_d;
            alloc_st_q  <= alloc_st_d;
            com_sqn_q   <= com_sqn_d;
            com_ld_q    <= com_ld_d;
            com_st_q    <= com_st_d;
            out_valid_q <= out_valid_d;
            out_sqn_q   <= out_sqn_d;
            out_ld_q    <= out_ld_d;
            out_st_q    <= out_st_d;
            rob_free_q  <= rob_free_d;
            lq_free_q   <= lq_free_d;
            sq_free_q   <= sq_free_d;
        end
    end

    assign OUT_valid    = out_valid_q;
    assign OUT_sqN      = out_sqn_q;
    assign OUT_loadSqN  = out_ld_q;
    assign OUT_storeSqN = out_st_q;
    assign OUT_robFree  = rob_free_q;
    assign OUT_lqFree   = lq_free_q;
    assign OUT_sqFree   = sq_free_q;

endmodule

`default_nettype wire
